// File: rtl/result_sender_if.sv
// Handshake and data bundle between the multiplier result, result_sender and uart_tx.
//   start    : one-cycle request to send result
//   result   : packed N_ELEM x ELEM_W matrix, element k = result[k*ELEM_W +: ELEM_W]
//   tx_busy  : busy flag from uart_tx
//   tx_data  : byte presented to uart_tx
//   tx_start : one-cycle launch pulse to uart_tx
//   busy     : high from accepted start until done
//   done     : one-cycle pulse after the last byte finishes
// master = result_sender side, slave = surrounding logic / uart_tx side.
interface result_sender_if #(
  parameter int unsigned N_ELEM = 9,
  parameter int unsigned ELEM_W = 16
) ();
  logic                     start;
  logic [N_ELEM*ELEM_W-1:0] result;
  logic                     tx_busy;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, result, tx_busy,
    output tx_data, tx_start, busy, done
  );

  modport slave (
    output start, result, tx_busy,
    input  tx_data, tx_start, busy, done
  );
endinterface

// File: rtl/result_sender.sv
// result_sender: serializes the packed 3x3 product matrix into a byte stream
// for uart_tx. The matrix is latched on start; an optional header byte is sent
// first, then each element most-significant byte first, one byte per
// tx_start/tx_busy handshake.
// Ports:
//   clk  : clock (uart_tx baud clock domain)
//   rst  : synchronous active-high reset
//   bus  : result_sender_if.master (start, result, tx_busy in;
//          tx_data, tx_start, busy, done out)
module result_sender #(
  parameter int unsigned N_ELEM    = 9,
  parameter int unsigned ELEM_W    = 16,
  parameter int unsigned HEADER_EN = 1,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  result_sender_if.master  bus
);

  localparam int unsigned BPE   = ELEM_W / 8;
  localparam int unsigned NDB   = N_ELEM * BPE;
  localparam int unsigned NB    = HEADER_EN + NDB;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_shadow;

  // Shadow is kept in transmit order (byte p = p-th data byte on the wire),
  // so the send path is a plain index mux with no divide/modulo by BPE.
  logic [7:0] res_bytes [NDB];
  logic [7:0] shadow_q  [NDB];
  logic [7:0] byte_sel;

  for (genvar e = 0; e < N_ELEM; e++) begin : g_elem
    for (genvar b = 0; b < BPE; b++) begin : g_byte
      assign res_bytes[e*BPE + b] = bus.result[e*ELEM_W + (BPE-1-b)*8 +: 8];
    end
  end

  // Index 0 is the header when enabled; data positions are offset by HEADER_EN.
  always_comb begin
    byte_sel = HEADER;
    for (int unsigned p = 0; p < NDB; p++) begin
      if (idx_q == IDX_W'(p + HEADER_EN)) begin
        byte_sel = shadow_q[p];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_shadow = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_shadow = 1'b1;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = byte_sel;
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        tx_start_d = 1'b1;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Datapath only; the FSM never reads the shadow outside a sequence.
  always_ff @(posedge clk) begin
    if (load_shadow) begin
      for (int unsigned p = 0; p < NDB; p++) begin
        shadow_q[p] <= res_bytes[p];
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/result_sender.md
# result_sender

Serializes the 3x3 product matrix from the multiplier into a byte stream for the UART transmitter, the transmit-side counterpart of the matrix-receive path. Latches the packed result on `start`, optionally emits a header byte, then sends every element MSB-byte-first through a start/busy handshake with `uart_tx`. Sits between the multiplier output and `uart_tx`, replacing the receive-data loopback on the transmitter's data input.

## Interface
- `N_ELEM`, 9: number of result elements.
- `ELEM_W`, 16: bits per element; must be a multiple of 8.
- `HEADER_EN`, 1: 1 = send `HEADER` byte before the data.
- `HEADER`, 8'hA5: header byte value.
- `clk`  in  1  single clock (the baud clock domain of `uart_tx`).
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to send `result`; honoured only in IDLE.
- `result`  in  N_ELEM*ELEM_W  packed matrix; element k = `result[k*ELEM_W +: ELEM_W]`, element 0 = row0/col0, row-major.
- `tx_busy`  in  1  busy flag from `uart_tx`.
- `tx_data`  out  8  byte presented to `uart_tx`.
- `tx_start`  out  1  one-cycle pulse launching a byte.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last byte finishes.

## Operation
- Byte count `NB = HEADER_EN + N_ELEM*ELEM_W/8` (19 by default). Internal byte index counts 0..NB-1, no wrap.
- Order: header (if enabled), then element 0..N_ELEM-1; within an element, most significant byte first.
- States: IDLE, LOAD, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE: on `start`, copy `result` into a shadow register, clear byte index, `busy`<=1, go to LOAD. `start` in any other state is ignored; the shadow is not touched.
- LOAD: drive `tx_data` with the byte at the current index; go to LAUNCH.
- LAUNCH: `tx_start`=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for `tx_busy`=1, then go to WAIT_DONE. If `tx_busy` was already high on entry it counts as the ack.
- WAIT_DONE: wait for `tx_busy`=0. If index = NB-1, go to FINISH; else increment index, go to LOAD.
- FINISH: `done`=1 for one cycle, `busy`<=0, go to IDLE.
- `tx_data` is held constant from LOAD until leaving WAIT_DONE.
- Changes to `result` after acceptance do not affect the stream.

## Timing
- Reset values: `tx_data`=8'h00, `tx_start`=0, `busy`=0, `done`=0, state IDLE, index 0.
- `start` sampled at edge T: `busy` high after T, `tx_data` valid after T+1, `tx_start` high during cycle T+2..T+3.
- Per byte: 2 cycles (LOAD, LAUNCH) + ack wait + UART busy time + 1 cycle to reach the next LOAD/FINISH.
- `done` asserts the cycle after the edge where the final `tx_busy` falling edge is sampled. `busy` falls on the same edge that clears `done`.
- `start` coincident with `done` is ignored (state is FINISH). A new `start` is accepted the cycle after `done`.
- `rst` at any edge, including mid-byte: all outputs return to reset values on that edge, the sequence is abandoned, and nothing resumes after reset. A `uart_tx` frame already in flight is not aborted by this block.
- `tx_busy` glitch-free behaviour is required from `uart_tx`. There is no timeout; a stuck-high `tx_busy` stalls the block in WAIT_DONE.

## Test plan
- Default params, result element k = 16'h0100*k + k (e.g. e0=0000, e1=0101, e8=0808). Bench model of `uart_tx` holds busy 10 cycles after `tx_start` -> 19 bytes A5,00,00,01,01,...,08,08 in order, exactly one `tx_start` per byte, one `done` pulse, `busy` low after it.
- Change `result` to all-FF one cycle after `start` -> stream still carries the latched values.
- Pulse `start` during byte 5 and again in the `done` cycle -> both ignored. `start` the cycle after `done` -> second full 19-byte stream.
- HEADER_EN=0, result e0=16'hBEEF, others 0 -> first bytes BE,EF, total 18 bytes.
- Assert `rst` while in WAIT_DONE of byte 7 -> next cycle `tx_start`=0, `busy`=0, `tx_data`=00. No further `tx_start` until a new `start`.
- Model `tx_busy` rising the same cycle as `tx_start` vs. 3 cycles later -> identical byte stream, no duplicate or skipped bytes.
